// File: rtl/mbox_pkg.sv
// Shared types and constants for the MBOX error-capture slice.
// Holds the capture sequencer state enum, the default channel numbering of
// the classic five-flag MBOX error set, and the default field widths.
package mbox_pkg;

    // Page-fail sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RETRY = 2'd2,
        ST_DRAIN = 2'd3
    } mbox_err_state_t;

    // Default channel numbering; lower index wins on simultaneous errors
    localparam int unsigned ERR_CSH_ADR_PAR = 0;
    localparam int unsigned ERR_MB_PAR      = 1;
    localparam int unsigned ERR_ADR_PAR     = 2;
    localparam int unsigned ERR_NXM         = 3;
    localparam int unsigned ERR_SBUS        = 4;

    // Default field widths (VMA width covers VMA bits 27:35)
    localparam int unsigned DISP_W_DEF = 11;
    localparam int unsigned VMA_W_DEF  = 9;

endpackage

// File: rtl/mbox_err_prio.sv
// Combinational lowest-index priority encoder.
// Ports:
//   req   - request vector, bit 0 has the highest priority
//   hit   - at least one request bit is set
//   idx   - index of the lowest set bit (0 when no bit is set)
//   multi - more than one request bit is set
module mbox_err_prio
    import mbox_pkg::*;
#(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic             multi
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        hit   = |req;
        multi = |(req & (req - N'(1)));
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mbox_err_capture.sv
// MBOX error capture and page-fail sequencer.
// Latches the first (highest-priority) error with its VMA and dispatch code,
// then runs the page-fail-hold / EBOX retry handshake:
//   IDLE -> HOLD (error) -> RETRY (ebox_t0) -> DRAIN (ebox_ack) -> IDLE/HOLD
// Optional per-channel saturating error counters when MBOX_ERR_COUNT_EN is
// defined (adds cnt_clr / err_cnt ports).
// Ports:
//   clk, CROBAR        - clock, asynchronous active-high reset
//   err_in             - per-channel error strobes
//   vma_in             - gated VMA, valid with any err_in bit
//   disp_in            - per-channel dispatch codes, channel i at [i*DISP_W +: DISP_W]
//   ebox_t0, ebox_ack  - EBOX accepts page fail / acknowledges retry
//   page_fail_hold     - hold the MBOX pipeline
//   ebox_retry_req     - retry request to the EBOX
//   cap_valid, cap_chan, cap_vma, cap_disp - captured error
//   multi_err          - sticky: an error was lost while a capture was held
//   cnt_clr, err_cnt   - counter clear / per-channel counts (MBOX_ERR_COUNT_EN)
module mbox_err_capture
    import mbox_pkg::*;
#(
    parameter int unsigned NCHAN  = 5,
    parameter int unsigned VMA_W  = VMA_W_DEF,
    parameter int unsigned DISP_W = DISP_W_DEF,
    parameter int unsigned CNT_W  = 4,
    localparam int unsigned CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                    clk,
    input  logic                    CROBAR,
    input  logic [NCHAN-1:0]        err_in,
    input  logic [VMA_W-1:0]        vma_in,
    input  logic [NCHAN*DISP_W-1:0] disp_in,
    input  logic                    ebox_t0,
    input  logic                    ebox_ack,
    output logic                    page_fail_hold,
    output logic                    ebox_retry_req,
    output logic                    cap_valid,
    output logic [CHAN_W-1:0]       cap_chan,
    output logic [VMA_W-1:0]        cap_vma,
    output logic [DISP_W-1:0]       cap_disp,
    output logic                    multi_err
`ifdef MBOX_ERR_COUNT_EN
    ,
    input  logic                    cnt_clr,
    output logic [NCHAN*CNT_W-1:0]  err_cnt
`endif
);

    mbox_err_state_t   state, state_nx;
    logic              hold_nx, retry_nx, valid_nx, multi_nx;
    logic [CHAN_W-1:0] chan_nx;
    logic [VMA_W-1:0]  vma_nx;
    logic [DISP_W-1:0] disp_nx;

    logic              prio_hit, prio_multi;
    logic [CHAN_W-1:0] prio_idx;
    logic [DISP_W-1:0] disp_sel;

    // Pick the winning channel
    mbox_err_prio #(
        .N     (NCHAN),
        .IDX_W (CHAN_W)
    ) u_prio (
        .req   (err_in),
        .hit   (prio_hit),
        .idx   (prio_idx),
        .multi (prio_multi)
    );

    // Dispatch code of the winning channel
    always_comb begin
        disp_sel = '0;
        for (int i = 0; i < int'(NCHAN); i++) begin
            if (prio_idx == CHAN_W'(i)) begin
                disp_sel = disp_in[i*DISP_W +: DISP_W];
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            state          <= ST_IDLE;
            page_fail_hold <= 1'b0;
            ebox_retry_req <= 1'b0;
            cap_valid      <= 1'b0;
            cap_chan       <= '0;
            cap_vma        <= '0;
            cap_disp       <= '0;
            multi_err      <= 1'b0;
        end else begin
            state          <= state_nx;
            page_fail_hold <= hold_nx;
            ebox_retry_req <= retry_nx;
            cap_valid      <= valid_nx;
            cap_chan       <= chan_nx;
            cap_vma        <= vma_nx;
            cap_disp       <= disp_nx;
            multi_err      <= multi_nx;
        end
    end

    // Next state, capture and handshake outputs
    always_comb begin
        state_nx = state;
        valid_nx = cap_valid;
        chan_nx  = cap_chan;
        vma_nx   = cap_vma;
        disp_nx  = cap_disp;
        multi_nx = multi_err;

        unique case (state)
            ST_IDLE, ST_DRAIN: begin
                state_nx = ST_IDLE;
                if (prio_hit) begin
                    state_nx = ST_HOLD;
                    valid_nx = 1'b1;
                    chan_nx  = prio_idx;
                    vma_nx   = vma_in;
                    disp_nx  = disp_sel;
                    multi_nx = multi_err | prio_multi;
                end
            end
            ST_HOLD: begin
                if (prio_hit) multi_nx = 1'b1;
                // A simultaneous ack is not honoured here; it must be re-presented in RETRY
                if (ebox_t0) state_nx = ST_RETRY;
            end
            ST_RETRY: begin
                if (prio_hit) multi_nx = 1'b1;
                // Ack releases the capture; an error in the same cycle is dropped with it
                if (ebox_ack) begin
                    state_nx = ST_DRAIN;
                    valid_nx = 1'b0;
                    multi_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        hold_nx  = (state_nx == ST_HOLD) || (state_nx == ST_RETRY);
        retry_nx = (state_nx == ST_RETRY);
    end

`ifdef MBOX_ERR_COUNT_EN
    // Per-channel saturating error counters; clear wins over increment
    always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR) begin
            err_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NCHAN); i++) begin
                if (cnt_clr) begin
                    err_cnt[i*CNT_W +: CNT_W] <= '0;
                end else if (err_in[i] && (err_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    err_cnt[i*CNT_W +: CNT_W] <= err_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: doc/mbox_err_capture.md
# mbox_err_capture

Parametrised MBOX error-capture and page-fail sequencer. It generalises the fixed five-flag MBOX error set (CSH address parity, MB parity, address parity, NXM, SBUS) to NCHAN prioritised channels. It latches the first error together with the gated VMA and page-fail dispatch code, and runs the page-fail-hold / EBOX-retry handshake. It sits between the MBOX error sources and the EBOX page-fail logic, driving the CSH page-fail-hold and EBOX retry-request signals.

## Interface
Parameters:
- NCHAN, 5: number of error channels; index 0 has the highest priority.
- VMA_W, 9: captured VMA width, corresponding to VMA bits 27:35.
- DISP_W, 11: page-fail dispatch code width.
- CNT_W, 4: width of each per-channel saturating counter. Used only when MBOX_ERR_COUNT_EN is defined.

Ports:
- clk  in  1  system clock. Single clock domain.
- CROBAR  in  1  reset, asynchronous, active-high.
- err_in  in  NCHAN  error strobes, sampled each clk.
- vma_in  in  VMA_W  gated VMA, valid whenever any err_in bit is high.
- disp_in  in  NCHAN*DISP_W  dispatch code per channel; channel i occupies slice [i*DISP_W +: DISP_W].
- ebox_t0  in  1  EBOX has reached T0 and accepts the page fail.
- ebox_ack  in  1  EBOX acknowledges the retry.
- page_fail_hold  out  1  hold the MBOX pipeline.
- ebox_retry_req  out  1  retry request to the EBOX.
- cap_valid  out  1  capture registers hold an error.
- cap_chan  out  $clog2(NCHAN)  channel that was captured.
- cap_vma  out  VMA_W  captured VMA.
- cap_disp  out  DISP_W  captured dispatch code.
- multi_err  out  1  sticky flag: an error was lost while a capture was held.
- cnt_clr  in  1  clear all counters. Present only when MBOX_ERR_COUNT_EN is defined.
- err_cnt  out  NCHAN*CNT_W  per-channel counts. Present only when MBOX_ERR_COUNT_EN is defined.

## Operation
State machine with four states: IDLE, HOLD, RETRY, DRAIN.

- **IDLE**
  - When any err_in bit is high: capture the lowest-index asserted channel, vma_in and that channel's disp_in slice; set cap_valid; go to HOLD.
  - Any other asserted bits in the same cycle set multi_err.
- **HOLD**
  - page_fail_hold=1.
  - On ebox_t0: go to RETRY.
- **RETRY**
  - page_fail_hold=1 and ebox_retry_req=1.
  - Both signals stay high until ebox_ack is seen.
  - On ebox_ack: clear cap_valid and multi_err; go to DRAIN.
- **DRAIN**
  - All outputs deasserted for one cycle.
  - Errors arriving in DRAIN are captured exactly as in IDLE, and the next state is HOLD.
  - With no error, the next state is IDLE.
- Any err_in bit in HOLD or RETRY sets multi_err. Capture registers are never overwritten in these states.
- ebox_t0 in IDLE or DRAIN is ignored. ebox_ack outside RETRY is ignored.
- ebox_t0 and ebox_ack high together in HOLD: the machine takes only HOLD→RETRY; the ack must be presented again in RETRY.
- Reset values: state=IDLE; all outputs 0; cap_chan/cap_vma/cap_disp=0; counters 0.
- CROBAR asserted mid-handshake drops page_fail_hold and ebox_retry_req asynchronously and discards the capture.

## Timing
- All outputs are registered.
- An error sampled at edge N makes cap_valid and page_fail_hold visible after edge N; latency is 1.
- ebox_t0 at edge M: ebox_retry_req rises after edge M.
- ebox_ack at edge K: hold, retry and cap_valid fall after edge K.
- Minimum gap between two captures is 2 cycles (RETRY→DRAIN→HOLD).
- cap_* fields stay stable for as long as cap_valid=1.

## Configuration
- **MBOX_ERR_COUNT_EN defined**
  - NCHAN saturating CNT_W counters.
  - Each asserted err_in bit increments its counter every cycle, in every state.
  - Counters stick at 2^CNT_W−1.
  - cnt_clr has priority over an increment in the same cycle.
- **MBOX_ERR_COUNT_EN undefined**
  - No counters, and the cnt_clr and err_cnt ports are absent.
  - The capture and handshake logic is identical.

## Structure
- Shared package mbox_pkg holds:
  - the state enum mbox_err_state_t;
  - default channel-index constants ERR_CSH_ADR_PAR=0, ERR_MB_PAR=1, ERR_ADR_PAR=2, ERR_NXM=3, ERR_SBUS=4;
  - DISP_W_DEF=11 and VMA_W_DEF=9.
- One sub-module, mbox_err_prio: a combinational, parametrised lowest-index priority encoder. It produces hit, index and a "more than one bit set" flag.

## Test plan
- err_in=5'b01000, vma_in=9'h1A5, ch3 disp=11'h2F0 → after 1 edge: cap_valid=1, cap_chan=3, cap_vma=1A5, cap_disp=2F0, page_fail_hold=1, multi_err=0.
- err_in=5'b10110 in IDLE → cap_chan=1, multi_err=1.
- Full handshake: ebox_t0 pulse 2 cycles after capture → retry_req=1; ack held off 5 cycles, so retry_req stays 1; ack → one cycle of all-zero outputs, then IDLE.
- err_in=5'b00001 while in RETRY → capture unchanged, multi_err=1; a new err_in=5'b00100 in DRAIN → HOLD with cap_chan=2.
- CROBAR pulsed while in RETRY → page_fail_hold=0, retry_req=0, cap_valid=0 immediately, without waiting for a clock edge.
- MBOX_ERR_COUNT_EN, CNT_W=4: ch4 held high 20 cycles → err_cnt[ch4]=15; cnt_clr together with err_in high → count=0.
